// File: rtl/ucode_seq_ctrl.sv
// rtl/ucode_seq_ctrl.sv - microcoded control sequencer driving datapath mux selects and load strobes
// A writable table of N_STEPS words is played out one word per cycle, with hold, abort and loop.
module ucode_seq_ctrl #(
  parameter  int N_STEPS = 20,
  parameter  int ADDR_W  = 5,
  parameter  int N_MUX   = 3,
  parameter  int SEL_W   = 2,
  parameter  int N_LD    = 4,
  localparam int UW      = 1 + N_LD + N_MUX*SEL_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_hold,
  input  logic                   i_loop,
  input  logic                   i_prog_we,
  input  logic [ADDR_W-1:0]      i_prog_addr,
  input  logic [UW-1:0]          i_prog_data,
  output logic [N_MUX*SEL_W-1:0] o_sel_out,
  output logic [N_LD-1:0]        o_ld_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ADDR_W-1:0]      o_step
);

  localparam int SW = N_MUX*SEL_W;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  logic [UW-1:0]       r_mem [N_STEPS];
  logic [SW-1:0]       r_sel;
  logic [N_LD-1:0]     r_ld;
  logic                r_busy;
  logic                r_done;
  logic                r_last;
  logic [ADDR_W-1:0]   r_step;

  logic [ADDR_W-1:0]   w_nxt_addr;
  logic [UW-1:0]       w_word0;
  logic [UW-1:0]       w_word_nxt;
  logic                w_final;
  logic                w_wr_ok;

  assign w_nxt_addr = r_step + ADDR_W'(1);
  assign w_word0    = r_mem[0];
  assign w_word_nxt = r_mem[w_nxt_addr];
  // The step-count bound guarantees termination even with a table lacking last bits.
  assign w_final    = r_last || (r_step == ADDR_W'(N_STEPS-1));
  assign w_wr_ok    = (r_state == S_IDLE) && i_prog_we && (int'(i_prog_addr) < N_STEPS);

  // Table has no reset so a program survives a controller reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_ld    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 1'b0;
      r_step  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_step  <= '0;
            r_sel   <= w_word0[SW-1:0];
            r_ld    <= w_word0[UW-2 -: N_LD];
            r_last  <= w_word0[UW-1];
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_step  <= '0;
            r_sel   <= '0;
            r_ld    <= '0;
            r_last  <= 1'b0;
          end else if (i_hold) begin
            r_ld   <= '0;
            r_done <= 1'b0;
          end else if (w_final) begin
            r_done <= 1'b1;
            if (i_loop) begin
              r_step <= '0;
              r_sel  <= w_word0[SW-1:0];
              r_ld   <= w_word0[UW-2 -: N_LD];
              r_last <= w_word0[UW-1];
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_step  <= '0;
              r_sel   <= '0;
              r_ld    <= '0;
              r_last  <= 1'b0;
            end
          end else begin
            r_done <= 1'b0;
            r_step <= w_nxt_addr;
            r_sel  <= w_word_nxt[SW-1:0];
            r_ld   <= w_word_nxt[UW-2 -: N_LD];
            r_last <= w_word_nxt[UW-1];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sel_out = r_sel;
  assign o_ld_out  = r_ld;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_step    = r_step;

endmodule

// File: tb/tb_ucode_seq_ctrl.sv
// tb/tb_ucode_seq_ctrl.sv - directed self-checking bench for ucode_seq_ctrl
module tb_ucode_seq_ctrl;

  localparam int UW = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, hold, loop_en, prog_we;
  logic [4:0]  prog_addr;
  logic [10:0] prog_data;
  logic [5:0]  sel_out;
  logic [3:0]  ld_out;
  logic        busy, done;
  logic [4:0]  step;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  ucode_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .i_abort    (abort),
    .i_hold     (hold),
    .i_loop     (loop_en),
    .i_prog_we  (prog_we),
    .i_prog_addr(prog_addr),
    .i_prog_data(prog_data),
    .o_sel_out  (sel_out),
    .o_ld_out   (ld_out),
    .o_busy     (busy),
    .o_done     (done),
    .o_step     (step)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic last, input logic [3:0] ld, input logic [5:0] sel);
    return {last, ld, sel};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int s, input int sl, input int ld,
                         input logic b, input logic d);
    chk({tag, ".step"}, 32'(step), 32'(s));
    chk({tag, ".sel"},  32'(sel_out), 32'(sl));
    chk({tag, ".ld"},   32'(ld_out), 32'(ld));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic prog(input logic [4:0] a, input logic [10:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; hold = 0; loop_en = 0;
    prog_we = 0; prog_addr = '0; prog_data = '0;
    cyc(); cyc();
    chk_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    prog(5'd0, mk(1'b0, 4'b0001, 6'b000000));
    prog(5'd1, mk(1'b0, 4'b0010, 6'b000001));
    prog(5'd2, mk(1'b1, 4'b0100, 6'b000010));
    chk_out("idle", 0, 0, 0, 0, 0);

    // T1 basic run
    go();
    chk_out("t1.w0", 0, 0, 1, 1, 0); cyc();
    chk_out("t1.w1", 1, 1, 2, 1, 0); cyc();
    chk_out("t1.w2", 2, 2, 4, 1, 0); cyc();
    chk_out("t1.done", 0, 0, 0, 0, 1); cyc();
    chk_out("t1.after", 0, 0, 0, 0, 0);

    // T2 hold for two cycles at step 1
    go();
    chk_out("t2.w0", 0, 0, 1, 1, 0); cyc();
    chk_out("t2.w1", 1, 1, 2, 1, 0);
    hold = 1'b1; cyc();
    chk_out("t2.h1", 1, 1, 0, 1, 0); cyc();
    chk_out("t2.h2", 1, 1, 0, 1, 0);
    hold = 1'b0; cyc();
    chk_out("t2.w2", 2, 2, 4, 1, 0); cyc();
    chk_out("t2.done", 0, 0, 0, 0, 1); cyc();
    chk_out("t2.after", 0, 0, 0, 0, 0);

    // T3 abort at step 1, then replay; abort in idle is a no-op
    go(); cyc();
    chk_out("t3.w1", 1, 1, 2, 1, 0);
    abort = 1'b1; cyc();
    chk_out("t3.abort", 0, 0, 0, 0, 0); cyc();
    chk_out("t3.idle_abort", 0, 0, 0, 0, 0);
    abort = 1'b0; cyc();
    chk_out("t3.nodone", 0, 0, 0, 0, 0);
    go();
    chk_out("t3.w0", 0, 0, 1, 1, 0); cyc(); cyc(); cyc();
    chk_out("t3.done", 0, 0, 0, 0, 1); cyc();

    // T4 loop mode
    loop_en = 1'b1;
    go();
    chk_out("t4.w0a", 0, 0, 1, 1, 0); cyc();
    chk_out("t4.w1a", 1, 1, 2, 1, 0); cyc();
    chk_out("t4.w2a", 2, 2, 4, 1, 0); cyc();
    chk_out("t4.w0b", 0, 0, 1, 1, 1); cyc();
    chk_out("t4.w1b", 1, 1, 2, 1, 0);
    start = 1'b1; cyc(); start = 1'b0;
    chk_out("t4.w2b", 2, 2, 4, 1, 0);
    loop_en = 1'b0; cyc();
    chk_out("t4.done", 0, 0, 0, 0, 1); cyc();
    chk_out("t4.after", 0, 0, 0, 0, 0);

    // T5 writes while busy and out of range are dropped
    go();
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 11'h7FF; cyc(); prog_we = 1'b0;
    chk_out("t5.w1", 1, 1, 2, 1, 0); cyc(); cyc();
    chk_out("t5.done", 0, 0, 0, 0, 1); cyc();
    prog(5'd25, 11'h7FF);
    go();
    chk_out("t5.r0", 0, 0, 1, 1, 0); cyc();
    chk_out("t5.r1", 1, 1, 2, 1, 0); cyc();
    chk_out("t5.r2", 2, 2, 4, 1, 0); cyc();
    chk_out("t5.rdone", 0, 0, 0, 0, 1); cyc();

    // Write and start on the same edge: old w0 issued, new w0 next run
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = mk(1'b0, 4'b1000, 6'b000011);
    start = 1'b1; cyc(); start = 1'b0; prog_we = 1'b0;
    chk_out("t5.same0", 0, 0, 1, 1, 0); cyc(); cyc(); cyc(); cyc();
    go();
    chk_out("t5.new0", 0, 3, 8, 1, 0); cyc(); cyc(); cyc(); cyc();

    // T6 full-depth program with no last bits
    for (int i = 0; i < 20; i++) prog(5'(i), mk(1'b0, 4'(i*3+1), 6'(i+5)));
    go();
    for (int i = 0; i < 20; i++) begin
      chk_out($sformatf("t6.s%0d", i), i, (i+5) & 63, (i*3+1) & 15, 1, 0);
      cyc();
    end
    chk_out("t6.done", 0, 0, 0, 0, 1); cyc();
    go(); cyc(); cyc();
    chk_out("t6.mid", 2, 7, 7, 1, 0);
    reset = 1'b1; cyc();
    chk_out("t6.reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    go();
    chk_out("t6.re0", 0, 5, 1, 1, 0); cyc();
    chk_out("t6.re1", 1, 6, 4, 1, 0); cyc();
    chk_out("t6.re2", 2, 7, 7, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
